// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the reg_file_sb register file with pending-write scoreboard.
package reg_file_sb_pkg;

  localparam int unsigned RF_DATA_W      = 32;
  localparam int unsigned RF_REG_COUNT   = 16;
  localparam int unsigned RF_ADDRESS_LEN = 4;
  localparam int unsigned RF_RD_PORTS    = 2;
  localparam int unsigned RF_CNT_W       = 2;

  // Number of writeback ports retiring a given register this cycle (0..2).
  function automatic logic [1:0] rf_dec_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rf_pending_cnt.sv
// Saturating up/down pending-write counter for one register; err pulses on under/overflow.
module rf_pending_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [1:0]       dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W:0]   w_dec;

  assign w_sum = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(inc);
  assign w_dec = (CNT_W+1)'(dec);

  // Flush discards outstanding marks but keeps the same-cycle issue.
  always_comb begin
    w_nxt = r_cnt;
    err   = 1'b0;
    if (clr) begin
      w_nxt = CNT_W'(inc);
    end else if (w_dec > w_sum) begin
      w_nxt = '0;
      err   = 1'b1;
    end else if (inc && (r_cnt == CNT_MAX) && (dec == 2'd0)) begin
      w_nxt = r_cnt;
      err   = 1'b1;
    end else begin
      w_nxt = CNT_W'(w_sum - w_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_nxt;
  end

  assign cnt  = r_cnt;
  assign full = (r_cnt == CNT_MAX);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with dual writeback and per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks onto read data and hazards.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W         = RF_DATA_W,
  parameter int unsigned REG_COUNT      = RF_REG_COUNT,
  parameter int unsigned ADDR_W         = RF_ADDRESS_LEN,
  parameter int unsigned RD_PORTS       = RF_RD_PORTS,
  parameter int unsigned CNT_W          = RF_CNT_W,
  parameter int unsigned RESET_TO_INDEX = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_hazard,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_dest,
  output logic                       issue_full,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_dest,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       wb2_en,
  input  logic [ADDR_W-1:0]          wb2_dest,
  input  logic [DATA_W-1:0]          wb2_data,
  input  logic                       flush,
  output logic                       sb_error
);

  logic [DATA_W-1:0]    r_regs [REG_COUNT];
  logic [CNT_W-1:0]     w_cnt  [REG_COUNT];
  logic [1:0]           w_dec  [REG_COUNT];
  logic [REG_COUNT-1:0] w_full;
  logic [REG_COUNT-1:0] w_err;
  logic                 r_sb_error;

  // Port B written first so port A wins on a shared destination.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++)
        r_regs[i] <= (RESET_TO_INDEX != 0) ? DATA_W'(i) : '0;
    end else begin
      if (wb2_en) r_regs[wb2_dest] <= wb2_data;
      if (wb_en)  r_regs[wb_dest]  <= wb_data;
    end
  end

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_cnt
    logic w_inc;
    assign w_inc    = issue_en && (issue_dest == ADDR_W'(r));
    assign w_dec[r] = rf_dec_count(wb_en && (wb_dest == ADDR_W'(r)),
                                   wb2_en && (wb2_dest == ADDR_W'(r)));
    rf_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (w_inc),
      .dec  (w_dec[r]),
      .clr  (flush),
      .cnt  (w_cnt[r]),
      .full (w_full[r]),
      .err  (w_err[r])
    );
  end

  assign issue_full = w_full[issue_dest];

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    assign w_ra = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[p*DATA_W +: DATA_W] =
      (wb_en  && (wb_dest  == w_ra)) ? wb_data  :
      (wb2_en && (wb2_dest == w_ra)) ? wb2_data : r_regs[w_ra];
    assign rd_hazard[p] = (CNT_W+2)'(w_cnt[w_ra]) > (CNT_W+2)'(w_dec[w_ra]);
`else
    assign rd_data[p*DATA_W +: DATA_W] = r_regs[w_ra];
    assign rd_hazard[p] = (w_cnt[w_ra] != '0);
`endif
  end

  // Scoreboard errors are sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst)        r_sb_error <= 1'b0;
    else if (|w_err) r_sb_error <= 1'b1;
  end

  assign sb_error = r_sb_error;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters, either bypass build).
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_hazard;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        issue_full;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb2_en;
  logic [3:0]  wb2_dest;
  logic [31:0] wb2_data;
  logic        flush;
  logic        sb_error;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_sb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_hazard  (rd_hazard),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .issue_full (issue_full),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .wb2_en     (wb2_en),
    .wb2_dest   (wb2_dest),
    .wb2_data   (wb2_data),
    .flush      (flush),
    .sb_error   (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic rd(input int p0, input int p1);
    rd_addr = {4'(p1), 4'(p0)};
  endtask

  // Advance past the next edge and drop all single-cycle strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    wb_en    = 1'b0;
    wb2_en   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rd_addr = '0;
    issue_en = 1'b0; issue_dest = '0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0;
    wb2_en = 1'b0; wb2_dest = '0; wb2_data = '0;
    flush = 1'b0;
    do_reset();

    // Reset contents, no hazards, no error.
    for (int r = 0; r < 16; r++) begin
      rd(r, 15 - r);
      #1;
      chk("rst_p0", rd_data[31:0], 32'(r));
      chk("rst_p1", rd_data[63:32], 32'(15 - r));
      chk("rst_haz", 32'(rd_hazard), 32'd0);
    end
    chk("rst_err", 32'(sb_error), 32'd0);
    chk("rst_full", 32'(issue_full), 32'd0);

    // Issue r3, writeback two cycles later.
    rd(3, 3);
    issue_en = 1'b1; issue_dest = 4'd3;
    #1 chk("t2_haz_pre", 32'(rd_hazard), 32'd0);
    tick();
    chk("t2_haz_c1", 32'(rd_hazard), 32'h3);
    tick();
    chk("t2_haz_c2", 32'(rd_hazard), 32'h3);
    wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t2_haz_wb", 32'(rd_hazard), 32'h0);
    chk("t2_dat_wb", rd_data[31:0], 32'hDEADBEEF);
`else
    chk("t2_haz_wb", 32'(rd_hazard), 32'h3);
    chk("t2_dat_wb", rd_data[31:0], 32'd3);
`endif
    tick();
    chk("t2_haz_post", 32'(rd_hazard), 32'h0);
    chk("t2_dat_post", rd_data[63:32], 32'hDEADBEEF);

    // Two pending writes on r5 retired by both ports at once.
    rd(5, 0);
    issue_en = 1'b1; issue_dest = 4'd5;
    tick();
    issue_en = 1'b1; issue_dest = 4'd5;
    tick();
    chk("t3_haz_pend", 32'(rd_hazard), 32'h1);
    wb_en  = 1'b1; wb_dest  = 4'd5; wb_data  = 32'hA;
    wb2_en = 1'b1; wb2_dest = 4'd5; wb2_data = 32'hB;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t3_haz_wb", 32'(rd_hazard), 32'h0);
    chk("t3_dat_wb", rd_data[31:0], 32'hA);
`else
    chk("t3_haz_wb", 32'(rd_hazard), 32'h1);
    chk("t3_dat_wb", rd_data[31:0], 32'd5);
`endif
    tick();
    chk("t3_dat", rd_data[31:0], 32'hA);
    chk("t3_haz", 32'(rd_hazard), 32'h0);
    chk("t3_err", 32'(sb_error), 32'd0);

    // Saturate r7 and overflow it.
    rd(7, 7);
    for (int k = 0; k < 3; k++) begin
      issue_en = 1'b1; issue_dest = 4'd7;
      tick();
    end
    issue_dest = 4'd7;
    #1 chk("t4_full", 32'(issue_full), 32'd1);
    chk("t4_err_pre", 32'(sb_error), 32'd0);
    issue_en = 1'b1;
    tick();
    chk("t4_err_ovf", 32'(sb_error), 32'd1);
    chk("t4_full_held", 32'(issue_full), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) chk("t4_haz_last", 32'(rd_hazard), 32'h3);
      wb_en = 1'b1; wb_dest = 4'd7; wb_data = 32'h70 + 32'(k);
      tick();
    end
    chk("t4_haz_done", 32'(rd_hazard), 32'h0);
    chk("t4_full_done", 32'(issue_full), 32'd0);
    chk("t4_dat", rd_data[31:0], 32'h72);

    // Flush with same-cycle issue, then an underflow.
    do_reset();
    chk("t5_err_rst", 32'(sb_error), 32'd0);
    chk("t5_r3_rst", 32'(dut.r_regs[3]), 32'd3);
    issue_en = 1'b1; issue_dest = 4'd1; tick();
    issue_en = 1'b1; issue_dest = 4'd1; tick();
    issue_en = 1'b1; issue_dest = 4'd2; tick();
    rd(1, 2);
    #1 chk("t5_haz_pre", 32'(rd_hazard), 32'h3);
    flush = 1'b1; issue_en = 1'b1; issue_dest = 4'd2;
    wb_en = 1'b1; wb_dest = 4'd1; wb_data = 32'h11;
    tick();
    chk("t5_haz_flush", 32'(rd_hazard), 32'h2);
    chk("t5_dat_flush", rd_data[31:0], 32'h11);
    chk("t5_err_flush", 32'(sb_error), 32'd0);
    wb_en = 1'b1; wb_dest = 4'd4; wb_data = 32'h44;
    tick();
    chk("t5_err_udf", 32'(sb_error), 32'd1);
    rd(4, 2);
    #1 chk("t5_dat_r4", rd_data[31:0], 32'h44);
    chk("t5_haz_r2", 32'(rd_hazard), 32'h2);

    // Reset overrides a coincident write and issue.
    rst = 1'b0;
    wb_en = 1'b1; wb_dest = 4'd9; wb_data = 32'h55;
    issue_en = 1'b1; issue_dest = 4'd9;
    tick();
    rst = 1'b1;
    rd(9, 4);
    #1;
    chk("t6_dat_r9", rd_data[31:0], 32'd9);
    chk("t6_dat_r4", rd_data[63:32], 32'd4);
    chk("t6_haz", 32'(rd_hazard), 32'h0);
    chk("t6_err", 32'(sb_error), 32'd0);
    tick();
    chk("t6_haz_next", 32'(rd_hazard), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
